dart_match: RTL
===============

# dart_match

Downstream stage of the per-round dart scorer. Consumes one round result per handshake (two throw points plus the round bonus flag) and plays a fixed-length match of `ROUNDS` rounds. It keeps the running score, counts rounds and bonus rounds, applies a streak reward, and declares win/lose against `TARGET` when the match ends.

## Interface
- `ROUNDS`, default 5: rounds per match; legal range 1..15.
- `TARGET`, default 20: minimum final score for `win`.
- `SCORE_W`, default 6: width of `score`.

- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `start`  input  1: begin a new match; honoured only in IDLE and DONE.
- `round_valid`  input  1: round result present on `p1`/`p2`/`bonus`.
- `p1`  input  2: first-throw points, 0..3.
- `p2`  input  2: second-throw points, 0..3.
- `bonus`  input  1: round bonus flag from the round scorer.
- `round_ready`  output  1: high only in PLAY; a round is accepted when `round_valid & round_ready`.
- `score`  output  SCORE_W: running total, saturating.
- `round_cnt`  output  4: rounds accepted in this match.
- `bonus_cnt`  output  4: accepted rounds with `bonus`=1.
- `busy`  output  1: high in PLAY.
- `done`  output  1: high in DONE.
- `win`  output  1: valid while `done`=1; 1 iff final `score` ≥ `TARGET`.

## Operation
- The FSM has three states: IDLE, PLAY, DONE. Reset puts it in IDLE.
- IDLE → PLAY on `start`. This clears `score`, `round_cnt`, `bonus_cnt`, the streak counter and `win`.
- DONE → PLAY on `start`, with the same clears.
- `start` in PLAY is ignored.
- `round_valid` in IDLE or DONE is ignored and has no side effects.
- Round value on accept: `p1 + p2 + (bonus ? 2 : 0)`, range 0..8.
- Streak counter, 2 bits internal:
  - An accept with `bonus`=1 increments it.
  - An accept with `bonus`=0 clears it.
  - When an accept brings it to 3, the round value gets +4 and the streak counter returns to 0.
- Score update: `score` ← min(`score` + round value, 2^SCORE_W−1). Compute the sum at least SCORE_W+4 bits wide before saturating.
- `round_cnt` increments on every accept. `bonus_cnt` increments on accepts with `bonus`=1.
- PLAY → DONE on the accept that makes `round_cnt` = `ROUNDS`. `win` is registered on that same edge from the post-update score.
- DONE holds all counters, `score` and `win` until `start` or `rst`.
- Input legality (`bonus` consistent with `p1`/`p2`) is not checked. The values are used as given.

## Timing
- Reset values: state IDLE; `round_ready`, `busy`, `done`, `win` = 0; `score`, `round_cnt`, `bonus_cnt`, streak = 0.
- `start` sampled at edge k gives `busy`=1 and `round_ready`=1 after edge k, with counters cleared at that edge.
- Accept at edge k: updated `score`, `round_cnt` and `bonus_cnt` are visible after edge k (latency 1).
- Back-to-back accepts on every cycle are supported, one round per clock.
- Final accept at edge k: after edge k, `done`=1, `busy`=0, `round_ready`=0, and final `score`/`win` are valid in the same cycle.
- `round_ready` is a pure function of state. It does not depend combinationally on `round_valid`.
- `rst` has priority over every other input in the same cycle. Reset mid-match returns to IDLE with all outputs at reset values.
- `start` and `round_valid` high together in IDLE: only the start is taken. No round is accepted because `round_ready` was 0.

## Test plan
- Reset and idle: assert `rst` for 2 cycles, then drive `round_valid`=1 with `p1`=3, `p2`=3 in IDLE → all outputs stay 0, `round_ready`=0, `done`=0.
- Full bonus match (ROUNDS=5, TARGET=20, SCORE_W=6): `start`, then 5 consecutive accepts of (3,3,1) → `score` sequence 8, 16, 28, 36, 44; `bonus_cnt`=5; `done`=1 and `win`=1 one cycle after the 5th accept.
- Broken streak: bonus pattern 1,1,0,1,1 with `p1`=`p2`=2 → no +4 awarded; final `score` = 6+6+4+6+6 = 28; `win`=1.
- Low score: rounds (1,0,0) then four of (0,0,0) → `score`=1, `win`=0, `bonus_cnt`=0, `round_cnt`=5.
- Saturation (SCORE_W=4): five accepts of (3,3,1) → `score` 8, then held at 15 for the remaining rounds; `win`=0 when TARGET=20.
- Control corner cases:
  - `start` pulse mid-match → ignored; counters continue.
  - `rst` after the 3rd accept → IDLE with all outputs 0.
  - `start` in DONE → new match with `score`=0 and `round_cnt`=0 after one edge.
  - `round_valid` with gaps (valid every other cycle) → same final `score` as the back-to-back case.

Source files
------------

// File: rtl/dart_match.sv
// -----------------------------------------------------------------------------
// dart_match
//
// Plays a fixed-length dart match of ROUNDS rounds. One round result is taken
// per valid/ready handshake. For each accepted round the block updates a
// saturating running score, counts rounds and bonus rounds, and tracks a
// streak of bonus rounds. The final accept decides win/lose against TARGET.
//
// Parameters:
//   ROUNDS  - rounds per match, 1..15
//   TARGET  - minimum final score for a win
//   SCORE_W - width of the score output
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   start       in   begin a new match (taken in IDLE and DONE only)
//   round_valid in   round result present on p1/p2/bonus
//   p1, p2      in   throw points, 0..3 each
//   bonus       in   round bonus flag
//   round_ready out  high in PLAY; accept = round_valid & round_ready
//   score       out  running total, saturating at 2^SCORE_W-1
//   round_cnt   out  rounds accepted in this match
//   bonus_cnt   out  accepted rounds that carried bonus
//   busy        out  high in PLAY
//   done        out  high in DONE
//   win         out  final score >= TARGET, valid while done
// -----------------------------------------------------------------------------
module dart_match #(
    parameter int ROUNDS  = 5,
    parameter int TARGET  = 20,
    parameter int SCORE_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               round_valid,
    input  logic [1:0]         p1,
    input  logic [1:0]         p2,
    input  logic               bonus,
    output logic               round_ready,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         round_cnt,
    output logic [3:0]         bonus_cnt,
    output logic               busy,
    output logic               done,
    output logic               win
);

    // Sum width leaves headroom above the score so the overflow test is exact.
    localparam int SUM_W = SCORE_W + 4;
    localparam logic [SUM_W-1:0]   SUM_MAX   = SUM_W'({SCORE_W{1'b1}});
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [3:0]         LAST_CNT  = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]         streak;
    logic [1:0]         streak_next;
    logic [SUM_W-1:0]   round_val;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_sat;
    logic               win_next;
    logic               accept;
    logic               last_round;
    logic               start_take;

    // Outputs decoded from state only; round_ready never looks at round_valid.
    assign round_ready = (state == S_PLAY);
    assign busy        = (state == S_PLAY);
    assign done        = (state == S_DONE);

    assign accept     = round_valid & round_ready;
    assign last_round = (round_cnt == LAST_CNT);
    assign start_take = start & (state != S_PLAY);

    // -------------------------------------------------------------------------
    // Round value, streak reward and saturating score
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        round_val   = SUM_W'(p1) + SUM_W'(p2);
        streak_next = 2'd0;

        if (bonus) begin
            round_val   = round_val + SUM_W'(2);
            streak_next = streak + 2'd1;
            // Third bonus in a row: reward and restart the streak.
            if (streak_next == 2'd3) begin
                round_val   = round_val + SUM_W'(4);
                streak_next = 2'd0;
            end
        end

        sum       = SUM_W'(score) + round_val;
        score_sat = (sum > SUM_MAX) ? SCORE_MAX : sum[SCORE_W-1:0];
        win_next  = (32'(score_sat) >= TARGET);
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_PLAY;
            S_PLAY:  if (accept && last_round) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_PLAY;
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Match datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || start_take) begin
            score     <= '0;
            round_cnt <= '0;
            bonus_cnt <= '0;
            streak    <= '0;
            win       <= 1'b0;
        end else if (accept) begin
            score     <= score_sat;
            round_cnt <= round_cnt + 4'd1;
            bonus_cnt <= bonus_cnt + 4'(bonus);
            streak    <= streak_next;
            if (last_round) begin
                win <= win_next;
            end
        end
    end

endmodule
